branch_predict_unit: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating counters and an integrated branch/jump target adder. It is the parametrised successor of the plain PC+4 + (offset<<2) adder.
- Fetch side: combinational lookup returns predicted-taken and predicted target for the fetch PC.
- Resolve side (ID stage): computes the real target for branch, jump and register-jump. Updates the table, and raises a registered redirect when the prediction was wrong.

---
 rtl/branch_predict_unit_pkg.sv | 20 ++
 rtl/branch_predict_unit_target_calc.sv | 23 ++
 rtl/branch_predict_unit.sv | 90 +++++++++
 tb/tb_branch_predict_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: shared mode/counter encodings, default widths and counter helper
package branch_predict_unit_pkg;
  localparam int BITS_SIZE_D = 32;
  localparam int IMM_SIZE_D  = 16;
  localparam int JIDX_SIZE_D = 26;
  localparam int ENTRIES_D   = 16;
  typedef enum logic [1:0] {
    MODE_BRANCH = 2'b00,
    MODE_JUMP   = 2'b01,
    MODE_JREG   = 2'b10,
    MODE_RSVD   = 2'b11
  } upd_mode_e;
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    return up ? (c == CNT_ST ? c : c + 2'd1) : (c == CNT_SNT ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_predict_unit_target_calc.sv
// branch_target_calc: combinational mode-muxed branch/jump target adder
// ports: mode selects branch (pc4+imm*4), jump (region|jidx*4), register jump, or reserved (pc4)
module branch_target_calc
  import branch_predict_unit_pkg::*;
#(
  parameter int BITS_SIZE = BITS_SIZE_D,
  parameter int IMM_SIZE  = IMM_SIZE_D,
  parameter int JIDX_SIZE = JIDX_SIZE_D
) (
  input  logic [1:0]           mode,
  input  logic [BITS_SIZE-1:0] pc4,
  input  logic [IMM_SIZE-1:0]  imm,
  input  logic [JIDX_SIZE-1:0] jidx,
  input  logic [BITS_SIZE-1:0] reg_target,
  output logic [BITS_SIZE-1:0] target
);
  logic [BITS_SIZE-1:0] br_off, jmp;
  assign br_off = {{(BITS_SIZE-IMM_SIZE-2){imm[IMM_SIZE-1]}}, imm, 2'b00};
  assign jmp    = {pc4[BITS_SIZE-1:JIDX_SIZE+2], jidx, 2'b00};
  assign target = mode == MODE_BRANCH ? pc4 + br_off :
                  mode == MODE_JUMP   ? jmp :
                  mode == MODE_JREG   ? reg_target : pc4;
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with 2-bit counters, resolve-side target calc and registered redirect
// ports: fetch side i_fetch_pc -> o_pred_taken/o_pred_target (combinational);
//        resolve side i_upd_* -> o_upd_target (combinational), o_redirect/o_redirect_pc (registered)
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int BITS_SIZE  = BITS_SIZE_D,
  parameter int IMM_SIZE   = IMM_SIZE_D,
  parameter int JIDX_SIZE  = JIDX_SIZE_D,
  parameter int ENTRIES    = ENTRIES_D,
  localparam int INDEX_BITS = $clog2(ENTRIES)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [BITS_SIZE-1:0] i_fetch_pc,
  output logic                 o_pred_taken,
  output logic [BITS_SIZE-1:0] o_pred_target,
  input  logic                 i_upd_valid,
  input  logic [1:0]           i_upd_mode,
  input  logic [BITS_SIZE-1:0] i_upd_pc,
  input  logic [BITS_SIZE-1:0] i_upd_pc4,
  input  logic [IMM_SIZE-1:0]  i_upd_imm,
  input  logic [JIDX_SIZE-1:0] i_upd_jidx,
  input  logic [BITS_SIZE-1:0] i_upd_reg_target,
  input  logic                 i_upd_taken,
  input  logic                 i_upd_pred_taken,
  input  logic [BITS_SIZE-1:0] i_upd_pred_target,
  output logic [BITS_SIZE-1:0] o_upd_target,
  output logic                 o_redirect,
  output logic [BITS_SIZE-1:0] o_redirect_pc
);
  localparam int TAG_BITS = BITS_SIZE - INDEX_BITS - 2;
  logic                 valid [ENTRIES];
  logic [1:0]           cnt   [ENTRIES];
  logic [TAG_BITS-1:0]  tag   [ENTRIES];
  logic [BITS_SIZE-1:0] tgt   [ENTRIES];
  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0]   f_tag, u_tag;
  logic f_hit, u_hit, eff_taken, upd_en, mispredict;
  logic unused_pc_low;
  assign unused_pc_low = ^{i_fetch_pc[1:0], i_upd_pc[1:0]};
  assign f_idx = i_fetch_pc[INDEX_BITS+1:2];
  assign f_tag = i_fetch_pc[BITS_SIZE-1:INDEX_BITS+2];
  assign u_idx = i_upd_pc[INDEX_BITS+1:2];
  assign u_tag = i_upd_pc[BITS_SIZE-1:INDEX_BITS+2];
  assign f_hit = valid[f_idx] && tag[f_idx] == f_tag;
  assign u_hit = valid[u_idx] && tag[u_idx] == u_tag;
  assign o_pred_taken  = f_hit && cnt[f_idx][1];
  assign o_pred_target = f_hit ? tgt[f_idx] : '0;
  branch_target_calc #(
    .BITS_SIZE (BITS_SIZE),
    .IMM_SIZE  (IMM_SIZE),
    .JIDX_SIZE (JIDX_SIZE)
  ) u_calc (
    .mode       (i_upd_mode),
    .pc4        (i_upd_pc4),
    .imm        (i_upd_imm),
    .jidx       (i_upd_jidx),
    .reg_target (i_upd_reg_target),
    .target     (o_upd_target)
  );
  // jumps are unconditional, so only conditional branches carry a real outcome
  assign eff_taken  = i_upd_mode == MODE_BRANCH ? i_upd_taken : 1'b1;
  assign upd_en     = i_upd_valid && i_upd_mode != MODE_RSVD;
  assign mispredict = (eff_taken != i_upd_pred_taken) || (eff_taken && i_upd_pred_target != o_upd_target);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        cnt[i]   <= CNT_WNT;
        tag[i]   <= '0;
        tgt[i]   <= '0;
      end
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
    end else begin
      o_redirect <= upd_en && mispredict;
      if (upd_en && mispredict) o_redirect_pc <= eff_taken ? o_upd_target : i_upd_pc4;
      if (upd_en && u_hit) begin
        cnt[u_idx] <= sat_step(cnt[u_idx], eff_taken);
        if (eff_taken) tgt[u_idx] <= o_upd_target;
      end else if (upd_en && eff_taken) begin
        valid[u_idx] <= 1'b1;
        tag[u_idx]   <= u_tag;
        tgt[u_idx]   <= o_upd_target;
        cnt[u_idx]   <= CNT_WT;
      end
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed plus randomized check against a behavioural BTB model
module tb_branch_predict_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [1:0]  upd_mode = '0;
  logic [31:0] upd_pc = '0, upd_pc4 = '0, reg_tgt = '0, upd_ptg = '0;
  logic [15:0] upd_imm = '0;
  logic [25:0] upd_jidx = '0;
  logic        upd_taken = 1'b0, upd_ptk = 1'b0;
  logic [31:0] upd_target, redirect_pc;
  logic        redirect;
  int n_cmp = 0, n_err = 0;

  bit          m_valid [16];
  int          m_cnt   [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  bit          exp_redir;
  logic [31:0] exp_rpc;

  branch_predict_unit dut (
    .i_clk(clk), .i_reset(rst), .i_fetch_pc(fetch_pc),
    .o_pred_taken(pred_taken), .o_pred_target(pred_target),
    .i_upd_valid(upd_valid), .i_upd_mode(upd_mode), .i_upd_pc(upd_pc), .i_upd_pc4(upd_pc4),
    .i_upd_imm(upd_imm), .i_upd_jidx(upd_jidx), .i_upd_reg_target(reg_tgt),
    .i_upd_taken(upd_taken), .i_upd_pred_taken(upd_ptk), .i_upd_pred_target(upd_ptg),
    .o_upd_target(upd_target), .o_redirect(redirect), .o_redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic logic [31:0] m_target();
    logic signed [31:0] off;
    off = {{16{upd_imm[15]}}, upd_imm};
    case (upd_mode)
      2'd0: return upd_pc4 + off * 4;
      2'd1: return (upd_pc4 & 32'hF000_0000) | ({6'b0, upd_jidx} << 2);
      2'd2: return reg_tgt;
      default: return upd_pc4;
    endcase
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == (pc >> 6);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_cnt[i] = 1; m_tag[i] = '0; m_tgt[i] = '0;
    end
    exp_redir = 0;
    exp_rpc   = '0;
  endtask

  task automatic model_update();
    logic [31:0] t;
    bit eff, mis;
    int i;
    if (rst) return;
    exp_redir = 0;
    if (!upd_valid || upd_mode == 2'd3) return;
    t   = m_target();
    eff = upd_mode == 2'd0 ? upd_taken : 1'b1;
    mis = (eff != upd_ptk) || (eff && upd_ptg != t);
    exp_redir = mis;
    if (mis) exp_rpc = eff ? t : upd_pc4;
    i = idx_of(upd_pc);
    if (m_hit(upd_pc)) begin
      m_cnt[i] = eff ? (m_cnt[i] == 3 ? 3 : m_cnt[i] + 1) : (m_cnt[i] == 0 ? 0 : m_cnt[i] - 1);
      if (eff) m_tgt[i] = t;
    end else if (eff) begin
      m_valid[i] = 1; m_tag[i] = upd_pc >> 6; m_tgt[i] = t; m_cnt[i] = 2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic upd(input logic [1:0] md, input logic [31:0] pc, input logic [31:0] pc4,
                     input logic [15:0] imm, input logic [25:0] jx, input logic [31:0] rt,
                     input logic tk, input logic ptk, input logic [31:0] ptg);
    upd_valid = 1; upd_mode = md; upd_pc = pc; upd_pc4 = pc4; upd_imm = imm;
    upd_jidx = jx; reg_tgt = rt; upd_taken = tk; upd_ptk = ptk; upd_ptg = ptg;
  endtask

  initial begin
    bit hit;
    forever begin
      @(negedge clk);
      hit = m_hit(fetch_pc);
      chk("pred_taken", {31'b0, pred_taken}, {31'b0, hit && m_cnt[idx_of(fetch_pc)] >= 2});
      chk("pred_target", pred_target, hit ? m_tgt[idx_of(fetch_pc)] : 32'h0);
      chk("upd_target", upd_target, m_target());
      chk("redirect", {31'b0, redirect}, {31'b0, exp_redir});
      chk("redirect_pc", redirect_pc, exp_rpc);
    end
  end

  initial begin
    model_reset();
    repeat (2) tick();
    rst = 0;
    fetch_pc = 32'h40;
    #1;
    chk("rst_pt", {31'b0, pred_taken}, 32'h0);
    chk("rst_ptg", pred_target, 32'h0);
    chk("rst_redir", {31'b0, redirect}, 32'h0);
    upd(2'd0, 32'h40, 32'h44, 16'h0003, '0, '0, 1, 0, '0);
    #1 chk("br_fwd_tgt", upd_target, 32'h50);
    tick();
    upd_valid = 0;
    chk("br_redir", {31'b0, redirect}, 32'h1);
    chk("br_rpc", redirect_pc, 32'h50);
    #1;
    chk("br_hit_pt", {31'b0, pred_taken}, 32'h1);
    chk("br_hit_ptg", pred_target, 32'h50);
    tick();
    chk("redir_pulse", {31'b0, redirect}, 32'h0);
    fetch_pc = 32'h104;
    upd(2'd0, 32'h104, 32'h44, 16'hFFFE, '0, '0, 1, 0, '0);
    #1 chk("br_back_tgt", upd_target, 32'h3C);
    tick();
    upd(2'd0, 32'h104, 32'h44, 16'hFFFE, '0, '0, 0, 1, 32'h3C);
    #1 chk("cnt10_pt", {31'b0, pred_taken}, 32'h1);
    tick();
    chk("nt_redir", {31'b0, redirect}, 32'h1);
    chk("nt_rpc", redirect_pc, 32'h44);
    upd(2'd0, 32'h104, 32'h44, 16'hFFFE, '0, '0, 0, 0, '0);
    #1 chk("cnt01_pt", {31'b0, pred_taken}, 32'h0);
    tick();
    chk("cnt00_noredir", {31'b0, redirect}, 32'h0);
    tick();
    chk("sat00_noredir", {31'b0, redirect}, 32'h0);
    upd(2'd0, 32'h104, 32'h44, 16'hFFFE, '0, '0, 1, 0, '0);
    tick();
    upd_valid = 0;
    #1 chk("sat00_then_up", {31'b0, pred_taken}, 32'h0);
    upd(2'd1, 32'h300, 32'h1000_0004, '0, 26'h100, '0, 0, 0, '0);
    #1 chk("jump_tgt", upd_target, 32'h1000_0400);
    tick();
    upd(2'd2, 32'h200, 32'h204, '0, '0, 32'h1234, 0, 1, 32'h1234);
    #1 chk("jreg_tgt", upd_target, 32'h1234);
    tick();
    upd_valid = 0;
    chk("jreg_noredir", {31'b0, redirect}, 32'h0);
    upd(2'd0, 32'h440, 32'h444, 16'h0010, '0, '0, 1, 0, '0);
    tick();
    upd_valid = 0;
    fetch_pc = 32'h40;
    #1 chk("alias_old_miss", {31'b0, pred_taken}, 32'h0);
    fetch_pc = 32'h440;
    #1 chk("alias_new_hit", {31'b0, pred_taken}, 32'h1);
    chk("alias_new_tgt", pred_target, 32'h484);
    fetch_pc = 32'h80;
    upd(2'd0, 32'h80, 32'h84, 16'h0001, '0, '0, 1, 0, '0);
    #1 chk("same_cyc_miss", {31'b0, pred_taken}, 32'h0);
    tick();
    upd_valid = 0;
    #1 chk("next_cyc_hit", {31'b0, pred_taken}, 32'h1);
    chk("next_cyc_tgt", pred_target, 32'h88);
    chk("pre_rst_redir", {31'b0, redirect}, 32'h1);
    rst = 1;
    model_reset();
    #1;
    chk("rst_drop_redir", {31'b0, redirect}, 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_clear_pt", {31'b0, pred_taken}, 32'h0);
    tick();
    rst = 0;
    tick();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      pc = ({30'b0, 2'($urandom_range(0, 3))} << 6) | ({28'b0, 4'($urandom_range(0, 15))} << 2);
      if ($urandom_range(0, 15) == 0) pc = pc | ($urandom & 32'hFFFF_F000);
      upd(2'($urandom_range(0, 3)), pc, pc + 4, 16'($urandom), 26'($urandom), $urandom,
          1'($urandom), 1'($urandom), $urandom);
      upd_valid = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 1) == 1) begin
        upd_ptk = m_hit(pc) && m_cnt[idx_of(pc)] >= 2;
        upd_ptg = $urandom_range(0, 3) == 0 ? $urandom : m_target();
      end
      fetch_pc = $urandom_range(0, 1) == 1 ? pc : ({30'b0, 2'($urandom_range(0, 3))} << 6) | ({28'b0, 4'($urandom_range(0, 15))} << 2);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1;
        model_reset();
        tick();
        rst = 0;
      end else begin
        tick();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
